// File: rtl/usb_rx_rcu.sv
// USB full-speed receive control unit: SYNC check, per-byte FIFO write strobe, error flagging.
// Optional first-byte PID check enabled by defining USB_RCU_PID_CHECK_EN.
module usb_rx_rcu #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);
    localparam int CW = $clog2(MAX_BYTES + 2);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE, WAIT_SYNC, CHK_SYNC, RCV, STORE, CHK_EOP, EOP_DONE, ERR_WAIT, ERR_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sync_q, sync_d;
    logic          rcving_q, rcving_d;
    logic          w_enable_q, w_enable_d;
    logic          r_error_q, r_error_d;
    logic          eop_tick;

    assign eop_tick = eop & shift_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sync_q     <= '0;
            rcving_q   <= 1'b0;
            w_enable_q <= 1'b0;
            r_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            rcving_q   <= rcving_d;
            w_enable_q <= w_enable_d;
            r_error_q  <= r_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sync_d  = sync_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (d_edge) state_d = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (byte_received) begin
                    state_d = CHK_SYNC;
                    sync_d  = rcv_data;
                end else if (eop_tick) begin
                    state_d = ERR_IDLE;
                end
            end
            CHK_SYNC: state_d = (sync_q == SYNC_BYTE) ? RCV : ERR_WAIT;
            RCV: begin
                // A completed byte wins over a coincident EOP sample.
                if (byte_received) begin
                    if (cnt_q == MAX_C) state_d = ERR_WAIT;
`ifdef USB_RCU_PID_CHECK_EN
                    else if (cnt_q == '0 && rcv_data[7:4] != ~rcv_data[3:0]) state_d = ERR_WAIT;
`endif
                    else state_d = STORE;
                end else if (eop_tick) begin
                    state_d = ERR_IDLE;
                end
            end
            STORE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = CHK_EOP;
            end
            CHK_EOP: if (shift_enable) state_d = eop ? EOP_DONE : RCV;
            EOP_DONE: if (d_edge) state_d = IDLE;
            ERR_WAIT: if (eop_tick) state_d = ERR_IDLE;
            ERR_IDLE: if (d_edge) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_comb begin
        rcving_d   = (state_d != IDLE) && (state_d != ERR_IDLE);
        w_enable_d = (state_d == STORE);
        r_error_d  = r_error_q;
        if (state_q == IDLE && state_d == WAIT_SYNC) r_error_d = 1'b0;
        if (state_d == ERR_WAIT || state_d == ERR_IDLE) r_error_d = 1'b1;
    end

    assign rcving   = rcving_q;
    assign w_enable = w_enable_q;
    assign r_error  = r_error_q;
endmodule
